// File: rtl/ahb_lite_timer_slave_if.sv
// AHB-Lite signal bundle between the bus fabric (master side) and the timer slave.
// HREADY is the bus-wide ready returned by the interconnect, so it travels master->slave.
interface ahb_lite_timer_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic [1:0]  HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_lite_timer_slave.sv
// AHB-Lite timer slave: 32-bit down-counter with CTRL/LOAD/VALUE/INTSTAT registers,
// programmable OKAY wait states, two-cycle ERROR responses and a level interrupt.
module ahb_lite_timer_slave #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] RESET_LOAD  = 32'h0000_0000
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahb_lite_timer_slave_if.slave bus,
  output logic                  TIMERINT
);
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [1:0] A_CTRL     = 2'd0;
  localparam logic [1:0] A_LOAD     = 2'd1;
  localparam logic [1:0] A_VALUE    = 2'd2;
  localparam logic [1:0] A_INTSTAT  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t      state, state_nxt;
  logic        pend, pend_nxt;      // a legal transfer owns the current data phase
  logic [1:0]  wcnt, wcnt_nxt;
  logic [1:0]  addr_q;
  logic        write_q;
  logic [2:0]  ctrl;                // [0] EN, [1] INTEN, [2] AUTORELOAD
  logic [31:0] load, value;
  logic        intstat;
  logic        ready, take, done, wr_en, underflow;
  logic [1:0]  resp;
  logic        accept, illegal;
  logic        unused_bits;

  assign accept      = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign illegal     = (bus.HSIZE != 3'b010) || (bus.HWRITE && (bus.HADDR[3:2] == A_VALUE));
  assign unused_bits = ^{bus.HADDR[31:4], bus.HADDR[1:0], bus.HTRANS[0]};

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can infer a latch.
    state_nxt = state;
    pend_nxt  = pend;
    wcnt_nxt  = wcnt;
    ready     = 1'b1;
    resp      = RESP_OKAY;
    done      = 1'b0;
    take      = 1'b0;
    unique case (state)
      S_IDLE: done = pend;
      S_WAIT: begin
        ready = 1'b0;
        if (wcnt == 2'd0) state_nxt = S_IDLE;
        else              wcnt_nxt  = wcnt - 2'd1;
      end
      S_ERR1: begin
        ready     = 1'b0;
        resp      = RESP_ERROR;
        state_nxt = S_ERR2;
      end
      S_ERR2: begin
        resp      = RESP_ERROR;
        state_nxt = S_IDLE;
      end
    endcase
    // New address phases are only taken while this slave is ready, so the data
    // phase completing now can be followed immediately by the next one.
    if (ready) begin
      pend_nxt = 1'b0;
      take     = accept;
      if (accept) begin
        if (illegal) begin
          state_nxt = S_ERR1;
        end else begin
          pend_nxt = 1'b1;
          if (WAIT_STATES != 0) begin
            state_nxt = S_WAIT;
            wcnt_nxt  = 2'(WAIT_STATES - 1);
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (HRESET) begin
      state   <= S_IDLE;
      pend    <= 1'b0;
      wcnt    <= 2'd0;
      addr_q  <= A_CTRL;
      write_q <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      wcnt  <= wcnt_nxt;
      if (take) begin
        addr_q  <= bus.HADDR[3:2];
        write_q <= bus.HWRITE;
      end
    end
  end

  assign wr_en     = done & write_q;
  assign underflow = ctrl[0] && (value == 32'd0);

  // Bus writes are issued after the timer update, so a LOAD or CTRL write wins over
  // the same-cycle decrement/EN clear; the INTSTAT set, however, beats a clear-write.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ctrl    <= 3'b000;
      load    <= RESET_LOAD;
      value   <= RESET_LOAD;
      intstat <= 1'b0;
    end else begin
      if (ctrl[0]) begin
        if (value != 32'd0)  value   <= value - 32'd1;
        else if (ctrl[2])    value   <= load;
        else                 ctrl[0] <= 1'b0;
      end
      if (underflow)
        intstat <= 1'b1;
      else if (wr_en && (addr_q == A_INTSTAT) && bus.HWDATA[0])
        intstat <= 1'b0;
      if (wr_en) begin
        case (addr_q)
          A_CTRL: ctrl <= bus.HWDATA[2:0];
          A_LOAD: begin
            load  <= bus.HWDATA;
            value <= bus.HWDATA;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.HRDATA = 32'd0;
    if (done && !write_q) begin
      unique case (addr_q)
        A_CTRL:    bus.HRDATA = {29'd0, ctrl};
        A_LOAD:    bus.HRDATA = load;
        A_VALUE:   bus.HRDATA = value;
        A_INTSTAT: bus.HRDATA = {31'd0, intstat};
      endcase
    end
  end

  assign bus.HREADYOUT = ready;
  assign bus.HRESP     = resp;
  assign TIMERINT      = intstat & ctrl[1];
endmodule

// File: tb/tb_ahb_lite_timer_slave.sv
// Directed bench for ahb_lite_timer_slave: a pipelined AHB driver pushes expected
// responses to a scoreboard queue; a small timer model supplies time-varying values.
module tb_ahb_lite_timer_slave;
  localparam logic [1:0] OKAY  = 2'b00;
  localparam logic [1:0] ERROR = 2'b01;
  localparam int         LIMIT = 400;

  typedef struct {
    string       tag;
    logic        wr;
    logic [1:0]  idx;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic [31:0] wdata;
    int          waits;
    logic [1:0]  resp;
    logic        chk_data;
    logic        use_model;
    logic [31:0] data;
  } item_t;

  item_t req_q[$];
  item_t exp_q[$];

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        dut_sel;          // 0: WAIT_STATES=1 instance, 1: WAIT_STATES=0 instance
  logic        t_hsel, t_hwrite;
  logic [31:0] t_haddr, t_hwdata;
  logic [1:0]  t_htrans;
  logic [2:0]  t_hsize;
  logic        int1, int0;
  logic        o_ready;
  logic [1:0]  o_resp;
  logic [31:0] o_rdata;
  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_fail = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_timer_slave_if bus1 ();
  ahb_lite_timer_slave_if bus0 ();

  assign bus1.HSEL   = t_hsel & ~dut_sel;
  assign bus0.HSEL   = t_hsel & dut_sel;
  assign bus1.HADDR  = t_haddr;   assign bus0.HADDR  = t_haddr;
  assign bus1.HTRANS = t_htrans;  assign bus0.HTRANS = t_htrans;
  assign bus1.HSIZE  = t_hsize;   assign bus0.HSIZE  = t_hsize;
  assign bus1.HWRITE = t_hwrite;  assign bus0.HWRITE = t_hwrite;
  assign bus1.HWDATA = t_hwdata;  assign bus0.HWDATA = t_hwdata;
  assign bus1.HREADY = bus1.HREADYOUT;
  assign bus0.HREADY = bus0.HREADYOUT;

  assign o_ready = dut_sel ? bus0.HREADYOUT : bus1.HREADYOUT;
  assign o_resp  = dut_sel ? bus0.HRESP     : bus1.HRESP;
  assign o_rdata = dut_sel ? bus0.HRDATA    : bus1.HRDATA;

  ahb_lite_timer_slave #(.WAIT_STATES(1), .RESET_LOAD(32'h0)) u_dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus1), .TIMERINT(int1)
  );
  ahb_lite_timer_slave #(.WAIT_STATES(0), .RESET_LOAD(32'h0)) u_dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus0), .TIMERINT(int0)
  );

  // Reference timer for the WAIT_STATES=1 instance; bus writes arrive via mdl_*.
  logic [2:0]  m_ctrl;
  logic [31:0] m_load, m_value;
  logic        m_int;
  logic        mdl_wr;
  logic [1:0]  mdl_idx;
  logic [31:0] mdl_data;

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      m_ctrl  <= 3'b000;
      m_load  <= 32'd0;
      m_value <= 32'd0;
      m_int   <= 1'b0;
    end else begin
      if (mdl_wr && mdl_idx == 2'd1) begin
        m_load  <= mdl_data;
        m_value <= mdl_data;
      end else if (m_ctrl[0]) begin
        m_value <= (m_value != 32'd0) ? m_value - 32'd1 : (m_ctrl[2] ? m_load : 32'd0);
      end
      if (mdl_wr && mdl_idx == 2'd0)
        m_ctrl <= mdl_data[2:0];
      else if (m_ctrl[0] && m_value == 32'd0 && !m_ctrl[2])
        m_ctrl <= {m_ctrl[2:1], 1'b0};
      m_int <= (m_ctrl[0] && m_value == 32'd0) ? 1'b1 :
               (mdl_wr && mdl_idx == 2'd3 && mdl_data[0]) ? 1'b0 : m_int;
    end
  end

  function automatic logic [31:0] model_rd(input logic [1:0] idx);
    case (idx)
      2'd0:    return {29'd0, m_ctrl};
      2'd1:    return m_load;
      2'd2:    return m_value;
      default: return {31'd0, m_int};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic item_t mk(input string tag, input logic wr, input logic [1:0] idx,
                               input logic [2:0] size, input logic [1:0] trans,
                               input logic [31:0] wdata, input int waits, input logic [1:0] resp,
                               input logic chk, input logic um, input logic [31:0] data);
    item_t it;
    it.tag = tag; it.wr = wr; it.idx = idx; it.size = size; it.trans = trans;
    it.wdata = wdata; it.waits = waits; it.resp = resp; it.chk_data = chk;
    it.use_model = um; it.data = data;
    return it;
  endfunction

  function automatic int ws();
    return dut_sel ? 0 : 1;
  endfunction

  task automatic q_wr(input string tag, input logic [1:0] idx, input logic [31:0] d);
    req_q.push_back(mk(tag, 1'b1, idx, 3'b010, 2'b10, d, ws(), OKAY, 1'b0, 1'b0, 32'd0));
  endtask
  task automatic q_rd(input string tag, input logic [1:0] idx, input logic [31:0] d);
    req_q.push_back(mk(tag, 1'b0, idx, 3'b010, 2'b10, 32'd0, ws(), OKAY, 1'b1, 1'b0, d));
  endtask
  task automatic q_rdm(input string tag, input logic [1:0] idx);
    req_q.push_back(mk(tag, 1'b0, idx, 3'b010, 2'b10, 32'd0, ws(), OKAY, 1'b1, 1'b1, 32'd0));
  endtask
  task automatic q_err(input string tag, input logic wr, input logic [1:0] idx,
                       input logic [2:0] size, input logic [31:0] d);
    req_q.push_back(mk(tag, wr, idx, size, 2'b10, d, 1, ERROR, 1'b0, 1'b0, 32'd0));
  endtask
  task automatic q_idle(input string tag);
    req_q.push_back(mk(tag, 1'b0, 2'd0, 3'b010, 2'b00, 32'd0, 0, OKAY, 1'b0, 1'b0, 32'd0));
  endtask

  // Drives queued requests back to back; one iteration per clock, at the falling edge.
  task automatic run();
    item_t      nxt, e;
    bit         have_dp = 0;
    bit         new_dp  = 0;
    int         waits   = 0;
    int         guard   = 0;
    logic [1:0] wresp   = 2'b00;
    exp_q.delete();
    while ((req_q.size() != 0 || have_dp || new_dp) && guard < LIMIT) begin
      @(negedge HCLK);
      guard++;
      mdl_wr = 1'b0;
      if (new_dp) begin
        have_dp  = 1; new_dp = 0; waits = 0;
        t_hwdata = nxt.wdata;
      end
      if (!dut_sel) check("timerint", 32'(int1), 32'(m_int & m_ctrl[1]));
      if (have_dp) begin
        if (!o_ready) begin
          waits++;
          if (waits == 1) wresp = o_resp;
        end else begin
          e = exp_q.pop_front();
          check({e.tag, "/waits"}, 32'(waits), 32'(e.waits));
          if (waits > 0) check({e.tag, "/wait_resp"}, 32'(wresp), 32'(e.resp));
          check({e.tag, "/resp"}, 32'(o_resp), 32'(e.resp));
          if (e.chk_data)
            check({e.tag, "/rdata"}, o_rdata, e.use_model ? model_rd(e.idx) : e.data);
          if (e.wr && e.resp == OKAY && !dut_sel) begin
            mdl_wr = 1'b1; mdl_idx = e.idx; mdl_data = t_hwdata;
          end
          have_dp = 0;
        end
      end
      if (o_ready) begin
        if (req_q.size() != 0) begin
          nxt      = req_q.pop_front();
          t_hsel   = 1'b1;
          t_haddr  = {28'h4000000, nxt.idx, 2'b00};
          t_hwrite = nxt.wr;
          t_hsize  = nxt.size;
          t_htrans = nxt.trans;
          exp_q.push_back(nxt);
          new_dp   = (nxt.trans[1] == 1'b1) || t_hsel;
        end else begin
          t_hsel   = 1'b0;
          t_htrans = 2'b00;
        end
      end
    end
    @(negedge HCLK);
    mdl_wr = 1'b0;
    check("run_in_time", 32'(guard >= LIMIT), 32'd0);
    req_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed still running, expected finished");
    $fatal(1);
  end

  initial begin
    dut_sel = 1'b0; HRESET = 1'b1;
    t_hsel = 1'b0; t_haddr = 32'd0; t_htrans = 2'b00; t_hsize = 3'b010;
    t_hwrite = 1'b0; t_hwdata = 32'd0;
    mdl_wr = 1'b0; mdl_idx = 2'd0; mdl_data = 32'd0;
    repeat (3) @(negedge HCLK);
    check("rst/hreadyout", 32'(o_ready), 32'd1);
    check("rst/hresp",     32'(o_resp),  32'(OKAY));
    check("rst/hrdata",    o_rdata,      32'd0);
    check("rst/timerint",  32'(int1),    32'd0);
    HRESET = 1'b0;

    q_rd("rst_ctrl", 2'd0, 32'd0);
    q_rd("rst_load", 2'd1, 32'd0);
    q_rd("rst_value", 2'd2, 32'd0);
    q_rd("rst_intstat", 2'd3, 32'd0);
    run();

    // One-shot countdown from 5 with interrupts enabled.
    q_wr("os_load", 2'd1, 32'd5);
    q_wr("os_ctrl", 2'd0, 32'h3);
    for (int i = 0; i < 6; i++) q_rdm($sformatf("os_value%0d", i), 2'd2);
    q_rd("os_ctrl_en_clear", 2'd0, 32'h2);
    q_rd("os_intstat", 2'd3, 32'd1);
    q_rd("os_value_hold", 2'd2, 32'd0);
    run();

    // Auto-reload period 3; clears land on different phases, one on an underflow.
    q_wr("ar_load", 2'd1, 32'd2);
    q_wr("ar_ctrl", 2'd0, 32'h7);
    for (int i = 0; i < 4; i++) q_rdm($sformatf("ar_value%0d", i), 2'd2);
    for (int i = 0; i < 4; i++) begin
      q_wr($sformatf("ar_clr%0d", i), 2'd3, 32'd1);
      q_rdm($sformatf("ar_intstat%0d", i), 2'd3);
      q_rdm($sformatf("ar_v%0d", i), 2'd2);
    end
    q_wr("ar_stop", 2'd0, 32'h6);
    q_rdm("ar_value_stopped", 2'd2);
    run();

    // Illegal accesses: two-cycle ERROR, no register change.
    q_err("err_half_rd_ctrl", 1'b0, 2'd0, 3'b001, 32'd0);
    q_rd("err_ctrl_keep", 2'd0, 32'h6);
    q_err("err_wr_value", 1'b1, 2'd2, 3'b010, 32'hDEAD_BEEF);
    q_rdm("err_value_keep", 2'd2);
    q_err("err_half_wr_load", 1'b1, 2'd1, 3'b001, 32'h0000_1234);
    q_rd("err_load_keep", 2'd1, 32'd2);
    run();

    // Zero-wait instance: pipelined writes, an IDLE transfer, then read-back.
    dut_sel = 1'b1;
    q_wr("ws0_load", 2'd1, 32'd7);
    q_wr("ws0_ctrl", 2'd0, 32'd1);
    q_idle("ws0_idle");
    q_rd("ws0_value", 2'd2, 32'd6);
    q_rd("ws0_load_rd", 2'd1, 32'd7);
    q_rd("ws0_ctrl_rd", 2'd0, 32'd1);
    run();
    check("ws0/timerint", 32'(int0), 32'd0);
    dut_sel = 1'b0;

    // Raise the interrupt, then reset asynchronously in the middle of a wait state.
    q_wr("rs_load", 2'd1, 32'd3);
    q_wr("rs_ctrl", 2'd0, 32'h3);
    for (int i = 0; i < 4; i++) q_rdm($sformatf("rs_value%0d", i), 2'd2);
    q_rd("rs_intstat", 2'd3, 32'd1);
    run();
    t_hsel = 1'b1; t_haddr = 32'h4; t_htrans = 2'b10; t_hwrite = 1'b0; t_hsize = 3'b010;
    @(posedge HCLK);
    #2;
    t_hsel = 1'b0; t_htrans = 2'b00;
    check("rs/in_wait", 32'(o_ready), 32'd0);
    check("rs/int_before", 32'(int1), 32'd1);
    HRESET = 1'b1;
    #1;
    check("rs/hreadyout", 32'(o_ready), 32'd1);
    check("rs/hresp", 32'(o_resp), 32'(OKAY));
    check("rs/timerint", 32'(int1), 32'd0);
    check("rs/hrdata", o_rdata, 32'd0);
    @(negedge HCLK);
    HRESET = 1'b0;
    q_rd("rs_ctrl", 2'd0, 32'd0);
    q_rd("rs_load_rd", 2'd1, 32'd0);
    q_rd("rs_value_rd", 2'd2, 32'd0);
    q_rd("rs_intstat_rd", 2'd3, 32'd0);
    run();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ahb_lite_timer_slave.md
Name: ahb_lite_timer_slave

Overview:
AHB-Lite slave (responder) holding a 32-bit down-counting timer with four word registers and an interrupt output. It sits on the processor's AHB-Lite master bus behind the address decoder. It completes transfers with a configurable number of wait states and returns two-cycle ERROR responses for illegal accesses. Its interrupt output feeds one bit of the processor IRQ vector.

Parameters:
WAIT_STATES, 1, number of HREADYOUT-low cycles inserted in every OKAY data phase (legal range 0..3)
RESET_LOAD, 32'h0000_0000, reset value of LOAD and VALUE

Ports:
HCLK  input  1  bus and timer clock
HRESET  input  1  asynchronous active-high reset
HSEL  input  1  slave select from decoder
HADDR  input  32  address; only [3:2] decoded, [31:4] ignored
HTRANS  input  2  transfer type; bit 1 set means NONSEQ/SEQ
HSIZE  input  3  transfer size
HWRITE  input  1  write when high
HWDATA  input  32  write data, valid in data phase
HREADY  input  1  bus-wide ready, qualifies the address phase
HRDATA  output  32  read data
HREADYOUT  output  1  slave ready
HRESP  output  2  00 OKAY, 01 ERROR
TIMERINT  output  1  level interrupt, INTSTAT[0] & CTRL.INTEN

Behaviour:
- Reset: HRDATA=0, HREADYOUT=1, HRESP=00, TIMERINT=0, CTRL=0, LOAD=VALUE=RESET_LOAD, INTSTAT=0, FSM=IDLE.
- Register map (HADDR[3:2]):
  - 0 CTRL: [0] EN, [1] INTEN, [2] AUTORELOAD; other bits read 0.
  - 1 LOAD: read/write.
  - 2 VALUE: read-only.
  - 3 INTSTAT: [0] underflow flag; a write of 1 to bit 0 clears it.
- Address phase is accepted when HSEL & HREADY & HTRANS[1]. HADDR[3:2] and HWRITE are captured at that edge.
- Illegal access: HSIZE != 3'b010, or a write to VALUE. These go to ERR1, then ERR2; no wait states and no register update.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=00.
    - Legal accept goes to WAIT if WAIT_STATES>0, otherwise the next cycle is the final data cycle (FSM stays in IDLE).
    - Illegal accept goes to ERR1.
    - IDLE/BUSY transfers, or HSEL=0, stay in IDLE with a zero-wait OKAY.
  - WAIT: HREADYOUT=0, HRESP=00. A counter runs from WAIT_STATES-1 down to 0, then the FSM moves to the final data cycle.
  - Final data cycle: HREADYOUT=1, HRESP=00.
    - Reads drive the current register value on HRDATA.
    - Writes sample HWDATA at this edge.
    - A new accept in this same cycle is honoured, so back-to-back pipelined transfers are supported.
  - ERR1: HREADYOUT=0, HRESP=01. Always goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=01. Then goes to IDLE, or accepts a new transfer in this cycle.
- HRDATA is 0 outside the final read data cycle.
- Timer, evaluated every HCLK while EN=1:
  - VALUE!=0: VALUE decrements by 1.
  - VALUE==0: INTSTAT[0] is set. VALUE reloads from LOAD if AUTORELOAD=1; otherwise VALUE stays 0 and EN clears.
  - VALUE wraps never; the decrement is unsigned.
- A write to LOAD also loads VALUE with the new data, overriding that cycle's decrement.
- If an INTSTAT clear-write coincides with an underflow in the same cycle, set wins and INTSTAT[0] stays 1.
- A CTRL write with EN=1 while VALUE==0 causes an underflow on the next enabled cycle.
- Asynchronous HRESET mid-transfer forces all state to reset values immediately; the pending transfer is abandoned.

Test Plan:
- Reset, then read CTRL/LOAD/VALUE/INTSTAT at WAIT_STATES=1 -> each read shows exactly 1 cycle HREADYOUT=0, then HRDATA = 0, 0, 0, 0 with HRESP=00.
- Write LOAD=5, write CTRL=3'b011, then poll VALUE -> VALUE counts 5..0. TIMERINT rises on the cycle after VALUE=0 is seen enabled. EN clears and VALUE holds 0.
- AUTORELOAD: LOAD=2, CTRL=3'b111 -> VALUE sequence 2,1,0,2,1,0. INTSTAT[0] is set at each underflow. Writing INTSTAT=1 clears it, unless it coincides with an underflow, in which case it stays 1.
- Halfword read (HSIZE=001) of CTRL -> HREADYOUT=0/HRESP=01, then HREADYOUT=1/HRESP=01, and CTRL is unchanged.
- Write 32'hDEAD_BEEF to VALUE -> two-cycle ERROR and VALUE is unaffected.
- Back-to-back NONSEQ writes (LOAD=7, CTRL=1) with WAIT_STATES=0, then HTRANS=IDLE with HSEL=1 -> both writes take effect in consecutive cycles and the IDLE gets a zero-wait OKAY.
- Assert HRESET during a WAIT cycle -> HREADYOUT=1, HRESP=00, all registers revert to reset values without waiting for a clock edge.
